// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and default timing shared by the UART receive and transmit controllers
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    localparam int OVS_DEF      = 16;
    localparam int BAUD_DIV_DEF = 27;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator, held at phase zero while clr_i is high
module uart_baud_tick #(
    parameter int BAUD_DIV = 27
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
    logic [CW-1:0] cnt_q;
    assign tick_o = ~clr_i & (cnt_q == LAST);
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) cnt_q <= '0;
        else        cnt_q <= (clr_i || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver with line synchroniser, oversampled frame FSM,
// one-entry valid/ready holding buffer and sticky framing/overrun flags
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF,
    parameter int OVS      = OVS_DEF,
    parameter int DATA_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    input  logic              en_i,
    input  logic              clr_err_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              busy_o
);
    localparam int SW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W);
    localparam logic [SW-1:0] S_MID = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_END = SW'(OVS - 1);
    localparam logic [BW-1:0] B_END = BW'(DATA_W - 1);

    logic              sync_q, cur_q, prev_q;
    rx_state_t         state_q;
    logic [SW-1:0]     s_q;
    logic [BW-1:0]     bit_q;
    logic [DATA_W-1:0] sh_q, data_q;
    logic              valid_q, fe_q, ov_q, busy_q;
    logic              tick, fall, done, good, bad;

    uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (state_q == IDLE),
        .tick_o(tick)
    );

    assign fall = prev_q & ~cur_q;
    assign done = en_i && tick && state_q == STOP && s_q == S_END;
    assign good = done & cur_q;
    assign bad  = done & ~cur_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) {prev_q, cur_q, sync_q} <= 3'b111;
        else        {prev_q, cur_q, sync_q} <= {cur_q, sync_q, rx_i};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            s_q     <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else if (!en_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (fall) begin
                    state_q <= START;
                    busy_q  <= 1'b1;
                    s_q     <= '0;
                end
                START: if (tick) begin
                    if (s_q != S_MID) s_q <= s_q + SW'(1);
                    else if (cur_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= DATA;
                        s_q     <= '0;
                        bit_q   <= '0;
                    end
                end
                DATA: if (tick) begin
                    s_q <= (s_q == S_END) ? '0 : s_q + SW'(1);
                    if (s_q == S_END) begin
                        sh_q  <= {cur_q, sh_q[DATA_W-1:1]};
                        bit_q <= bit_q + BW'(1);
                        if (bit_q == B_END) state_q <= STOP;
                    end
                end
                STOP: if (tick) begin
                    s_q <= (s_q == S_END) ? '0 : s_q + SW'(1);
                    if (s_q == S_END) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // A completed byte replaces the held one only if the buffer is empty or being drained
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            if (good && (!valid_q || ready_i)) data_q <= sh_q;
            valid_q <= good | (valid_q & ~ready_i);
            fe_q    <= bad | (fe_q & ~clr_err_i);
            ov_q    <= (good & valid_q & ~ready_i) | (ov_q & ~clr_err_i);
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = fe_q;
    assign overrun_o   = ov_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frame vectors and corner-case sequences for uart_rx_ctrl
module tb_uart_rx_ctrl;
    localparam int BD  = 4;
    localparam int OVS = 16;
    localparam int BIT = BD * OVS;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       rx_i = 1'b1;
    logic       en_i = 1'b1;
    logic       clr_err_i = 1'b0;
    logic       ready_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, overrun_o, busy_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       pre_clear;
        logic       exp_v;
        logic [7:0] exp_d;
        logic       exp_fe;
        logic       exp_ov;
    } vec_t;
    vec_t vecs[8];

    uart_rx_ctrl #(.BAUD_DIV(BD), .OVS(OVS), .DATA_W(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rx_i       (rx_i),
        .en_i       (en_i),
        .clr_err_i  (clr_err_i),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic idle);
        rx_i = 1'b0;
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            step(BIT);
        end
        rx_i = stop;
        step(BIT);
        rx_i = idle;
    endtask

    task automatic drain_clear();
        ready_i = 1'b1;
        clr_err_i = 1'b1;
        step();
        ready_i = 1'b0;
        clr_err_i = 1'b0;
    endtask

    initial begin
        logic saw_busy;
        vecs[0] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{8'h81, 1'b1, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0};
        vecs[4] = '{8'h11, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[5] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1};
        vecs[6] = '{8'h5A, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1};
        vecs[7] = '{8'h69, 1'b1, 1'b1, 1'b1, 8'h69, 1'b0, 1'b0};

        step(3);
        chk("rst_data", data_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_fe", frame_err_o, 0);
        chk("rst_ov", overrun_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_i = 1'b1;
        step(5);

        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                step(610);
                chk("t1_valid_before_c", valid_o, 0);
                step();
                chk("t1_valid_after_c", valid_o, 1);
                chk("t1_data", data_o, 8'hA5);
            end
        join
        chk("t1_fe", frame_err_o, 0);
        chk("t1_ov", overrun_o, 0);
        step(200);
        chk("t1_hold_valid", valid_o, 1);
        chk("t1_hold_data", data_o, 8'hA5);
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        chk("t1_drained", valid_o, 0);
        step(10);

        rx_i = 1'b0;
        step(20);
        rx_i = 1'b1;
        step(14);
        chk("t2_busy_in_start", busy_o, 1);
        step();
        chk("t2_busy_after_check", busy_o, 0);
        step(100);
        chk("t2_valid", valid_o, 0);
        chk("t2_fe", frame_err_o, 0);

        send_frame(8'h3C, 1'b0, 1'b0);
        chk("t3_fe", frame_err_o, 1);
        chk("t3_valid", valid_o, 0);
        clr_err_i = 1'b1;
        step();
        clr_err_i = 1'b0;
        chk("t3_fe_cleared", frame_err_o, 0);
        saw_busy = 1'b0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (busy_o) saw_busy = 1'b1;
        end
        chk("t3_break_no_retrigger", saw_busy, 0);
        chk("t3_break_valid", valid_o, 0);
        rx_i = 1'b1;
        step(10);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].pre_clear) drain_clear();
            send_frame(vecs[i].b, vecs[i].stop, 1'b1);
            step(5);
            chk($sformatf("vec%0d_valid", i), valid_o, vecs[i].exp_v);
            chk($sformatf("vec%0d_data", i), data_o, vecs[i].exp_d);
            chk($sformatf("vec%0d_fe", i), frame_err_o, vecs[i].exp_fe);
            chk($sformatf("vec%0d_ov", i), overrun_o, vecs[i].exp_ov);
        end

        drain_clear();
        chk("t5_start_empty", valid_o, 0);
        send_frame(8'h11, 1'b1, 1'b1);
        chk("t5_first_data", data_o, 8'h11);
        fork
            send_frame(8'h22, 1'b1, 1'b1);
            begin
                step(610);
                ready_i = 1'b1;
                step();
                ready_i = 1'b0;
            end
        join
        chk("t5_valid", valid_o, 1);
        chk("t5_data", data_o, 8'h22);
        chk("t5_ov", overrun_o, 0);

        fork
            send_frame(8'h5A, 1'b1, 1'b1);
            begin
                step(200);
                chk("t6_busy_pre_rst", busy_o, 1);
                #3;
                rst_i = 1'b0;
                #1;
                chk("t6_rst_data", data_o, 0);
                chk("t6_rst_valid", valid_o, 0);
                chk("t6_rst_busy", busy_o, 0);
                chk("t6_rst_fe", frame_err_o, 0);
                chk("t6_rst_ov", overrun_o, 0);
            end
        join
        rst_i = 1'b1;
        step(10);
        fork
            send_frame(8'h5A, 1'b1, 1'b1);
            begin
                step(300);
                chk("t6_busy_pre_en", busy_o, 1);
                en_i = 1'b0;
                step();
                chk("t6_busy_en_off", busy_o, 0);
            end
        join
        en_i = 1'b1;
        step(10);
        chk("t6_en_valid", valid_o, 0);
        chk("t6_en_fe", frame_err_o, 0);
        chk("t6_en_ov", overrun_o, 0);
        send_frame(8'h5A, 1'b1, 1'b1);
        step(5);
        chk("t6_clean_valid", valid_o, 1);
        chk("t6_clean_data", data_o, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
